// File: rtl/prbs_checker_16_pkg.sv
// -----------------------------------------------------------------------------
// prbs_checker_16_pkg
// Items shared by the PRBS-16 generator and checker: the LFSR width, the tap
// mask for x^16 + x^14 + x^13 + x^11 + 1, the one-step next-word function,
// and the checker state encoding.
// -----------------------------------------------------------------------------
package prbs_checker_16_pkg;

    localparam int          LFSR_W    = 16;
    // Taps sit on bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // One Fibonacci shift: the XOR of the tapped bits enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr16_next(input logic [LFSR_W-1:0] w);
        return {w[LFSR_W-2:0], ^(w & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/prbs_checker_16_err_counter.sv
// -----------------------------------------------------------------------------
// prbs_err_counter
// Status counters for the PRBS checker.
//   clk, reset        : clock, asynchronous active-high reset
//   i_clear           : synchronous clear; wins over a same-cycle increment
//   i_word_inc        : count one checked word (wrapping, 32 bits)
//   i_err_inc         : count one mismatch (saturating, ERR_W bits)
//   o_err_count       : mismatch count
//   o_word_count      : checked-word count
// -----------------------------------------------------------------------------
module prbs_err_counter #(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_word_inc,
    input  logic             i_err_inc,
    output logic [ERR_W-1:0] o_err_count,
    output logic [31:0]      o_word_count
);

    logic [ERR_W-1:0] r_err_count;
    logic [31:0]      r_word_count;

    // NOTE: state is written with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count  <= '0;
            r_word_count <= '0;
        end else if (i_clear) begin
            r_err_count  <= '0;
            r_word_count <= '0;
        end else begin
            if (i_word_inc) begin
                r_word_count <= r_word_count + 32'd1;
            end
            // Hold at all-ones rather than wrap back to a misleading small value.
            if (i_err_inc && (r_err_count != {ERR_W{1'b1}})) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign o_err_count  = r_err_count;
    assign o_word_count = r_word_count;

endmodule

// File: rtl/prbs_checker_16.sv
// -----------------------------------------------------------------------------
// prbs_checker_16
// Self-synchronising checker for the PRBS-16 word stream. Seeds its prediction
// from the first non-zero word, locks after LOCK_CNT consecutive correct
// predictions, then free-runs its own prediction and flags each deviation.
//   clk, reset   : clock, asynchronous active-high reset
//   data_valid   : data_in holds a new word this cycle
//   data_in      : received LFSR word
//   clear_cnt    : synchronous clear of err_count / word_count
//   locked       : checker is in LOCKED
//   error_pulse  : previous valid word mismatched while LOCKED
//   err_count    : saturating mismatch count while LOCKED
//   word_count   : wrapping count of words checked while LOCKED
// -----------------------------------------------------------------------------
module prbs_checker_16
    import prbs_checker_16_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_valid,
    input  logic [LFSR_W-1:0] data_in,
    input  logic              clear_cnt,
    output logic              locked,
    output logic              error_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [31:0]       word_count
);

    localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_CNT);

    state_t            r_state;
    logic [LFSR_W-1:0] r_expected;
    logic [3:0]        r_match_cnt;
    logic [3:0]        r_bad_cnt;
    logic              r_locked;
    logic              r_error_pulse;

    state_t            w_state_nxt;
    logic [LFSR_W-1:0] w_expected_nxt;
    logic [3:0]        w_match_nxt;
    logic [3:0]        w_bad_nxt;
    logic              w_error_nxt;
    logic              w_word_inc;
    logic              w_err_inc;
    logic              w_is_match;
    logic              w_is_zero;

    assign w_is_match = (data_in == r_expected);
    assign w_is_zero  = (data_in == '0);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_match_nxt    = r_match_cnt;
        w_bad_nxt      = r_bad_cnt;
        w_error_nxt    = 1'b0;
        w_word_inc     = 1'b0;
        w_err_inc      = 1'b0;

        if (data_valid) begin
            unique case (r_state)
                SEARCH: begin
                    // The all-zero word is the LFSR lock-up state and can never
                    // seed a valid prediction.
                    if (!w_is_zero) begin
                        w_expected_nxt = lfsr16_next(data_in);
                        w_match_nxt    = '0;
                        w_state_nxt    = CHECK;
                    end
                end
                CHECK: begin
                    if (w_is_match) begin
                        w_match_nxt    = r_match_cnt + 4'd1;
                        w_expected_nxt = lfsr16_next(r_expected);
                        if (r_match_cnt + 4'd1 == LOCK_TGT) begin
                            w_state_nxt = LOCKED;
                            w_bad_nxt   = '0;
                        end
                    end else if (w_is_zero) begin
                        w_match_nxt = '0;
                        w_state_nxt = SEARCH;
                    end else begin
                        w_expected_nxt = lfsr16_next(data_in);
                        w_match_nxt    = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: once locked the prediction never reseeds from
                    // the data, so a corrupted word costs exactly one error.
                    w_expected_nxt = lfsr16_next(r_expected);
                    w_word_inc     = 1'b1;
                    if (w_is_match) begin
                        w_bad_nxt = '0;
                    end else begin
                        w_error_nxt = 1'b1;
                        w_err_inc   = 1'b1;
                        w_bad_nxt   = r_bad_cnt + 4'd1;
                        if (r_bad_cnt + 4'd1 == UNLOCK_TGT) begin
                            w_state_nxt = SEARCH;
                        end
                    end
                end
                default: w_state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= SEARCH;
            r_expected    <= '0;
            r_match_cnt   <= '0;
            r_bad_cnt     <= '0;
            r_locked      <= 1'b0;
            r_error_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_expected    <= w_expected_nxt;
            r_match_cnt   <= w_match_nxt;
            r_bad_cnt     <= w_bad_nxt;
            r_locked      <= (w_state_nxt == LOCKED);
            r_error_pulse <= w_error_nxt;
        end
    end

    prbs_err_counter #(
        .ERR_W (ERR_W)
    ) u_err_counter (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (clear_cnt),
        .i_word_inc   (w_word_inc),
        .i_err_inc    (w_err_inc),
        .o_err_count  (err_count),
        .o_word_count (word_count)
    );

    assign locked      = r_locked;
    assign error_pulse = r_error_pulse;

endmodule

// File: tb/tb_prbs_checker_16.sv
// -----------------------------------------------------------------------------
// tb_prbs_checker_16
// Drives word streams into prbs_checker_16. A behavioural reference model
// predicts the outputs for every cycle; predictions are queued when stimulus
// is driven and compared after the clock edge that consumes it. Scenario tasks
// add targeted checks of the documented behaviour.
// -----------------------------------------------------------------------------
module tb_prbs_checker_16;

    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 4;
    localparam int ERR_W      = 4;   // small width so saturation is reachable
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic             clk;
    logic             reset;
    logic             data_valid;
    logic [15:0]      data_in;
    logic             clear_cnt;
    logic             locked;
    logic             error_pulse;
    logic [ERR_W-1:0] err_count;
    logic [31:0]      word_count;

    prbs_checker_16 #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT),
        .ERR_W      (ERR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .clear_cnt   (clear_cnt),
        .locked      (locked),
        .error_pulse (error_pulse),
        .err_count   (err_count),
        .word_count  (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic             lck;
        logic             ep;
        logic [ERR_W-1:0] errc;
        logic [31:0]      wc;
    } exp_t;

    exp_t sb_q[$];

    int               m_state;   // 0 search, 1 check, 2 locked
    logic [15:0]      m_exp;
    int               m_match;
    int               m_bad;
    logic             m_ep;
    logic [ERR_W-1:0] m_errc;
    logic [31:0]      m_wc;
    logic [15:0]      gen;       // true sequence position of the last word sent

    function automatic logic [15:0] nxt(input logic [15:0] w);
        return {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
    endfunction

    task automatic model_reset();
        m_state = 0; m_exp = '0; m_match = 0; m_bad = 0;
        m_ep = 1'b0; m_errc = '0; m_wc = '0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] d, input logic c);
        logic ep_n;
        logic inc_w;
        logic inc_e;
        ep_n = 1'b0; inc_w = 1'b0; inc_e = 1'b0;
        if (v) begin
            if (m_state == 0) begin
                if (d != 16'h0000) begin
                    m_exp = nxt(d); m_match = 0; m_state = 1;
                end
            end else if (m_state == 1) begin
                if (d == m_exp) begin
                    m_match++;
                    m_exp = nxt(m_exp);
                    if (m_match == LOCK_CNT) begin
                        m_state = 2; m_bad = 0;
                    end
                end else if (d == 16'h0000) begin
                    m_state = 0; m_match = 0;
                end else begin
                    m_exp = nxt(d); m_match = 0;
                end
            end else begin
                inc_w = 1'b1;
                if (d == m_exp) begin
                    m_bad = 0;
                end else begin
                    ep_n = 1'b1; inc_e = 1'b1; m_bad++;
                    if (m_bad == UNLOCK_CNT) m_state = 0;
                end
                m_exp = nxt(m_exp);
            end
        end
        if (c) begin
            m_errc = '0; m_wc = '0;
        end else begin
            if (inc_w) m_wc = m_wc + 1;
            if (inc_e && m_errc != ERR_MAX) m_errc = m_errc + 1'b1;
        end
        m_ep = ep_n;
    endtask

    // Drive one cycle (called just after a falling edge); returns at the next
    // falling edge with the DUT outputs for that cycle settled.
    task automatic step(input logic v, input logic [15:0] d, input logic c);
        data_valid = v;
        data_in    = d;
        clear_cnt  = c;
        model_step(v, d, c);
        sb_q.push_back('{lck: (m_state == 2), ep: m_ep, errc: m_errc, wc: m_wc});
        @(negedge clk);
        data_valid = 1'b0;
        clear_cnt  = 1'b0;
    endtask

    // Scoreboard: pop the prediction for the edge just taken.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if ({locked, error_pulse, err_count, word_count} !== e) begin
                n_fail++;
                $display("FAIL scoreboard @%0t: got lck=%b ep=%b err=%0d wc=%0d, expected lck=%b ep=%b err=%0d wc=%0d",
                         $time, locked, error_pulse, err_count, word_count,
                         e.lck, e.ep, e.errc, e.wc);
            end
        end
    end

    // Feed seed plus LOCK_CNT successors; leaves gen at the last word sent.
    task automatic send_lock_seq(input logic [15:0] seed);
        gen = seed;
        step(1'b1, gen, 1'b0);
        for (int i = 0; i < LOCK_CNT; i++) begin
            gen = nxt(gen);
            step(1'b1, gen, 1'b0);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; data_valid = 1'b0; data_in = '0; clear_cnt = 1'b0;
        model_reset();
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({locked, error_pulse, err_count, word_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: lck=%b ep=%b err=%0d wc=%0d, expected all 0",
                     locked, error_pulse, err_count, word_count);
        end
    endtask

    task automatic test_clean_lock();
        logic [15:0] seq [5];
        seq[0] = 16'h1001; seq[1] = 16'h2003; seq[2] = 16'h4007;
        seq[3] = 16'h800E; seq[4] = 16'h001D;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq[i], 1'b0);
            n_checks++;
            if (locked !== (i == 4)) begin
                n_fail++;
                $display("FAIL clean_lock_word%0d: locked=%b expected %b", i, locked, (i == 4));
            end
        end
        gen = 16'h001D;
        n_checks++;
        if (err_count !== '0 || word_count !== '0) begin
            n_fail++;
            $display("FAIL clean_lock_counts: err=%0d wc=%0d expected 0/0", err_count, word_count);
        end
    endtask

    task automatic test_single_error();
        gen = nxt(gen);
        step(1'b1, gen ^ 16'h0001, 1'b0);
        n_checks++;
        if ({locked, error_pulse, err_count} !== {1'b1, 1'b1, ERR_W'(1)}) begin
            n_fail++;
            $display("FAIL single_error: lck=%b ep=%b err=%0d expected 1/1/1", locked, error_pulse, err_count);
        end
        gen = nxt(gen);
        step(1'b1, gen, 1'b0);
        n_checks++;
        if ({locked, error_pulse, err_count, word_count} !== {1'b1, 1'b0, ERR_W'(1), 32'd2}) begin
            n_fail++;
            $display("FAIL flywheel_resume: lck=%b ep=%b err=%0d wc=%0d expected 1/0/1/2",
                     locked, error_pulse, err_count, word_count);
        end
    endtask

    task automatic test_loss_of_lock();
        step(1'b0, 16'h0000, 1'b1);   // start from cleared counters
        for (int i = 0; i < UNLOCK_CNT; i++) begin
            gen = nxt(gen);
            step(1'b1, 16'hFFFF, 1'b0);
            n_checks++;
            if (locked !== (i < UNLOCK_CNT - 1)) begin
                n_fail++;
                $display("FAIL unlock_bad%0d: locked=%b expected %b", i, locked, (i < UNLOCK_CNT - 1));
            end
        end
        n_checks++;
        if (err_count !== ERR_W'(UNLOCK_CNT)) begin
            n_fail++;
            $display("FAIL unlock_err_count: err=%0d expected %0d", err_count, UNLOCK_CNT);
        end
        send_lock_seq(16'hACE1);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL relock: locked=%b expected 1", locked);
        end
    endtask

    task automatic test_clear_collision();
        step(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            gen = nxt(gen);
            step(1'b1, gen ^ 16'h8000, 1'b0);
        end
        gen = nxt(gen);
        step(1'b1, gen, 1'b0);
        n_checks++;
        if (err_count !== ERR_W'(3)) begin
            n_fail++;
            $display("FAIL collide_setup: err=%0d expected 3", err_count);
        end
        gen = nxt(gen);
        step(1'b1, gen ^ 16'h0100, 1'b1);
        n_checks++;
        if ({locked, error_pulse, err_count, word_count} !== {1'b1, 1'b1, ERR_W'(0), 32'd0}) begin
            n_fail++;
            $display("FAIL clear_collision: lck=%b ep=%b err=%0d wc=%0d expected 1/1/0/0",
                     locked, error_pulse, err_count, word_count);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) begin
            gen = nxt(gen);
            step(1'b1, gen, 1'b0);
            gen = nxt(gen);
            step(1'b1, gen ^ 16'h0010, 1'b0);
        end
        n_checks++;
        if ({locked, error_pulse, err_count} !== {1'b1, 1'b1, ERR_MAX}) begin
            n_fail++;
            $display("FAIL err_saturate: lck=%b ep=%b err=%0d expected 1/1/%0d",
                     locked, error_pulse, err_count, ERR_MAX);
        end
    endtask

    task automatic test_zero_and_gaps();
        logic [31:0] wc_hold;
        test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0000, 1'b0);
        gen = 16'h5A5A;
        for (int i = 0; i <= LOCK_CNT; i++) begin
            if (i > 0) gen = nxt(gen);
            step(1'b1, gen, 1'b0);
            step(1'b0, 16'($urandom), 1'b0);
        end
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_lock: locked=%b expected 1", locked);
        end
        wc_hold = word_count;
        for (int i = 0; i < 3; i++) step(1'b0, 16'hDEAD, 1'b0);
        n_checks++;
        if ({locked, error_pulse, word_count} !== {1'b1, 1'b0, wc_hold}) begin
            n_fail++;
            $display("FAIL idle_hold: lck=%b ep=%b wc=%0d expected 1/0/%0d",
                     locked, error_pulse, word_count, wc_hold);
        end
    endtask

    task automatic test_async_reset();
        gen = nxt(gen);
        step(1'b1, ~gen, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({locked, error_pulse, err_count, word_count} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: lck=%b ep=%b err=%0d wc=%0d expected all 0",
                     locked, error_pulse, err_count, word_count);
        end
        model_reset();
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step(1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        reset = 1'b1; data_valid = 1'b0; data_in = '0; clear_cnt = 1'b0;
        gen = '0;
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss_of_lock();
        test_clear_collision();
        test_saturation();
        test_zero_and_gaps();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
